fios_seq_sched: RTL and testbench
=================================

# fios_seq_sched

Parametrised iteration scheduler for the folded FIOS Montgomery multiplier. It replaces per-PE control delay chains with a central counter-based schedule and issues these pulses at computed cycles:
- per-PE start pulses;
- a-register shift pulses;
- b/p operand-fetch windows;
- result-push window;
- completion pulse.

It generalises to any word count `S`, PE count `PE_NB`, PE skew and loop delay. It adds a busy indication, a dropped-start flag and an optional single-entry queue for back-to-back operations. It sits between the host operand/result FIFOs and the PE array.

## Interface
- `S`, 8: words per operand (≥2).
- `PE_NB`, 3: processing elements (1..S).
- `PE_DELAY`, 7: cycles between consecutive PE starts within a pass (≥1).
- `LOOP_DELAY`, 0: extra cycles on the PE ring return path.
- `RES_LAT`, 9: cycles from the last iteration's PE start to its first result word (≥1).

Ports:
- `clock_i`  in  1: clock.
- `reset_i`  in  1: synchronous, active-high reset.
- `start_i`  in  1: single-cycle request to begin a multiplication.
- `busy_o`  out  1: operation in progress.
- `pe_start_o`  out  PE_NB: one-hot start pulse for PE k.
- `a_shift_o`  out  1: shift the a register by PE_NB words.
- `b_fetch_o`  out  1: pop one b word.
- `p_fetch_o`  out  1: pop one p word.
- `RES_push_o`  out  1: push one result word.
- `done_o`  out  1: completion pulse.
- `start_drop_o`  out  1: a start request was discarded.
- `iter_o`  out  $clog2(S): index of the most recently started iteration.

## Operation
- Pass period: P = max(PE_NB*PE_DELAY + LOOP_DELAY, S+2), computed at elaboration.
- Number of passes: NP = ceil(S/PE_NB).
- Last iteration: index S-1, issued on PE KL = (S-1)%PE_NB in pass NP-1.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start_i`.
  - RUN→DRAIN on the cycle the last PE start is issued.
  - DRAIN→IDLE on the `done_o` cycle, or DRAIN→RUN on that cycle if a start is pending.
- Let t0 be the first RUN cycle. Within pass n (0..NP-1), iteration it = n*PE_NB + k is issued to PE k at cycle t0 + n*P + k*PE_DELAY, only if it < S. The final pass may be partial.
  - `pe_start_o[k]` pulses for one cycle at that issue cycle.
  - `iter_o` updates to it on the same cycle.
- `b_fetch_o` and `p_fetch_o` are high for S consecutive cycles starting at each pass start, t0 + n*P. Later PEs receive these words via the datapath skew.
- `a_shift_o` pulses once per pass, at pass start + (PE_NB-1)*PE_DELAY + 1. It does not pulse in the last pass.
- `RES_push_o` is high for S consecutive cycles starting RES_LAT cycles after the last PE start.
- `done_o` pulses on the cycle after the final `RES_push_o` cycle.
- `busy_o` is high from t0 through the `done_o` cycle inclusive.
- Counters:
  - pass counter is $clog2(NP+1) bits;
  - cycle-in-pass counter is $clog2(P) bits and wraps to 0 at P-1;
  - result counter is $clog2(S+1) bits;
  - no counter ever exceeds its terminal value.
- A start request arriving while `busy_o`=1 is handled according to Configuration.
- If `start_i` arrives on the `done_o` cycle, it counts as arriving while busy.

## Timing
- Reset value of every output is 0, including `iter_o`. Pending state and all counters are also cleared.
- Reset asserted mid-operation forces all outputs to 0 on the next cycle. No further pulses are emitted and the FSM returns to IDLE.
- Start latency: `start_i` is sampled at edge c. The first `pe_start_o[0]`, `b_fetch_o` and `busy_o` appear in cycle c+1.
- Total latency from `start_i` to `done_o`: 1 + (NP-1)*P + KL*PE_DELAY + RES_LAT + S cycles.
- All outputs are registered. No combinational path exists from `start_i` to any output.

## Configuration
- Macro: `FIOS_SEQ_SCHED_QUEUE_EN`.
- Defined:
  - a start while busy sets a one-entry pending flag;
  - the queued operation's t0 is the cycle after `done_o`, with no IDLE gap;
  - `start_drop_o` pulses only when a start arrives while pending is already set.
- Undefined:
  - every start while busy is discarded;
  - `start_drop_o` pulses on the cycle after the discarded request;
  - no pending storage is synthesised.

## Structure
- Package `fios_seq_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN);
  - `pass_period(S, PE_NB, PE_DELAY, LOOP_DELAY)`;
  - `num_passes(S, PE_NB)`.
- One sub-module, `fios_seq_window`: a loadable down-counter that emits a level of programmable length.
  - Instanced twice: once for the b/p fetch window and once for the RES push window.

## Test plan
- Reference schedule, with S=4, PE_NB=2, PE_DELAY=3, LOOP_DELAY=1, RES_LAT=5 (P=7), start at cycle 0, must produce:
  - `pe_start_o[0]` pulses at 1 and 8;
  - `pe_start_o[1]` pulses at 4 and 11;
  - `a_shift_o` pulses only at 5;
  - `b_fetch_o` is high for cycles 1-4 and 8-11;
  - `RES_push_o` is high for cycles 16-19;
  - `done_o` pulses at 20;
  - `busy_o` is high for cycles 1-20.
- Partial last pass, with S=3 and the other parameters as above:
  - `pe_start_o[1]` never pulses in pass 1;
  - `RES_push_o` is high for cycles 13-15;
  - `done_o` pulses at 16.
- Reset mid-operation: assert reset at cycle 9 of the reference case.
  - All outputs are 0 from cycle 10.
  - A new start at 12 reproduces the reference schedule shifted by 12.
- Back-to-back operation: in the reference case, start at 0 and again at 6.
  - With QUEUE_EN, the second operation has t0=21 and `start_drop_o` stays 0.
  - Without QUEUE_EN, `start_drop_o` pulses at 7 and only one `done_o` occurs.
- Start on the `done_o` cycle: `start_i` at cycle 20.
  - Without QUEUE_EN, the request is dropped and `start_drop_o` pulses at 21.
  - With QUEUE_EN, the new t0 is 21.
- Single PE, with PE_NB=1, S=2, PE_DELAY=1, LOOP_DELAY=0, RES_LAT=1 (P=4):
  - `pe_start_o[0]` pulses at 1 and 5;
  - `a_shift_o` pulses at 2;
  - `RES_push_o` is high for cycles 6-7;
  - `done_o` pulses at 8.

Source files
------------

// File: rtl/fios_seq_pkg.sv
// ---------------------------------------------------------------------------
// fios_seq_pkg
// Shared types and elaboration-time helpers for the FIOS iteration scheduler.
//   state_e      : scheduler FSM state (IDLE / RUN / DRAIN)
//   pass_period  : cycles per pass, max(PE ring round trip, S+2)
//   num_passes   : passes needed to issue S iterations over PE_NB PEs
// ---------------------------------------------------------------------------
package fios_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A pass must cover the full PE ring round trip and also leave room for the
  // S-word operand fetch plus two cycles of turnaround.
  function automatic int pass_period(int s, int pe_nb, int pe_delay, int loop_delay);
    int ring;
    ring = pe_nb * pe_delay + loop_delay;
    if (ring > s + 32'sd2) begin
      return ring;
    end else begin
      return s + 32'sd2;
    end
  endfunction

  function automatic int num_passes(int s, int pe_nb);
    return (s + pe_nb - 32'sd1) / pe_nb;
  endfunction

endpackage

// File: rtl/fios_seq_sched_if.sv
// ---------------------------------------------------------------------------
// fios_seq_sched_if
// Control bundle between the scheduler and the FIOS datapath / host FIFOs.
//   start_i      : request to begin a multiplication (host -> scheduler)
//   busy_o       : operation in progress
//   pe_start_o   : one-hot per-PE start pulse
//   a_shift_o    : shift a register by PE_NB words
//   b_fetch_o    : pop one b word
//   p_fetch_o    : pop one p word
//   RES_push_o   : push one result word
//   done_o       : completion pulse
//   start_drop_o : a start request was discarded
//   iter_o       : most recently started iteration index
// master = scheduler side, slave = datapath/host side.
// ---------------------------------------------------------------------------
interface fios_seq_sched_if #(
  parameter int PE_NB = 3,
  parameter int IW    = 3
);
  logic             start_i;
  logic             busy_o;
  logic [PE_NB-1:0] pe_start_o;
  logic             a_shift_o;
  logic             b_fetch_o;
  logic             p_fetch_o;
  logic             RES_push_o;
  logic             done_o;
  logic             start_drop_o;
  logic [IW-1:0]    iter_o;

  modport master (
    input  start_i,
    output busy_o, pe_start_o, a_shift_o, b_fetch_o, p_fetch_o,
           RES_push_o, done_o, start_drop_o, iter_o
  );

  modport slave (
    output start_i,
    input  busy_o, pe_start_o, a_shift_o, b_fetch_o, p_fetch_o,
           RES_push_o, done_o, start_drop_o, iter_o
  );
endinterface

// File: rtl/fios_seq_window.sv
// ---------------------------------------------------------------------------
// fios_seq_window
// Loadable down-counter producing a registered level that stays high for LEN
// consecutive cycles after a load. A load during an active window restarts it.
//   clock_i : clock
//   reset_i : synchronous active-high reset
//   load_i  : start a new window (level rises on the following cycle)
//   level_o : registered window level
//   last_o  : high during the final cycle of the window
// ---------------------------------------------------------------------------
module fios_seq_window #(
  parameter int LEN = 8,
  parameter int CW  = $clog2(LEN + 1)
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic load_i,
  output logic level_o,
  output logic last_o
);

  logic [CW-1:0] cnt_q;
  logic          lvl_q;

  // Count remaining window cycles; the count never exceeds LEN-1
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= CW'(LEN - 1);
      lvl_q <= 1'b1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(32'd1);
      lvl_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q;
      lvl_q <= 1'b0;
    end
  end

  assign level_o = lvl_q;
  assign last_o  = lvl_q && (cnt_q == '0);

endmodule

// File: rtl/fios_seq_sched.sv
// ---------------------------------------------------------------------------
// fios_seq_sched
// Central counter-based iteration scheduler for the folded FIOS Montgomery
// multiplier. Issues per-PE starts, a-register shifts, b/p fetch windows,
// the result push window and a completion pulse.
// Ports:
//   clock_i : clock
//   reset_i : synchronous active-high reset
//   bus     : fios_seq_sched_if.master (start_i in, all schedule outputs out)
// Optional build macro FIOS_SEQ_SCHED_QUEUE_EN: a start arriving while busy
// is held in a one-entry pending flag and launched right after done_o.
// Without it, every start while busy is dropped and flagged on start_drop_o.
// ---------------------------------------------------------------------------
module fios_seq_sched
  import fios_seq_pkg::*;
#(
  parameter int S          = 8,
  parameter int PE_NB      = 3,
  parameter int PE_DELAY   = 7,
  parameter int LOOP_DELAY = 0,
  parameter int RES_LAT    = 9
) (
  input  logic              clock_i,
  input  logic              reset_i,
  fios_seq_sched_if.master  bus
);

  localparam int P   = pass_period(S, PE_NB, PE_DELAY, LOOP_DELAY);
  localparam int NP  = num_passes(S, PE_NB);
  localparam int CW  = $clog2(P);
  localparam int PW  = $clog2(NP + 1);
  localparam int IW  = $clog2(S);
  localparam int LW  = $clog2(RES_LAT + 1);
  localparam int RW  = $clog2(S + 1);
  // Offset of the a-register shift inside a pass: just after the last PE start
  localparam int ASH = (PE_NB - 1) * PE_DELAY + 1;

  state_e           state_q;
  logic [CW-1:0]    cyc_q;
  logic [PW-1:0]    pass_q;
  logic [LW-1:0]    lat_q;
  logic             busy_q;
  logic [PE_NB-1:0] pe_start_q;
  logic             a_shift_q;
  logic             done_q;
  logic             drop_q;
  logic [IW-1:0]    iter_q;

  logic [CW-1:0]    cyc_nx_s;
  logic [PW-1:0]    pass_nx_s;
  logic [PE_NB-1:0] issue_s;
  int               issue_it_s;
  logic             issue_last_s;
  logic             ashift_nx_s;
  logic             busy_s;
  logic             done_cyc_s;
  logic             launch_s;
  logic             drop_s;
  logic             fetch_load_s;
  logic             res_load_s;
  logic             fetch_lvl_s;
  logic             fetch_last_unused_s;
  logic             res_lvl_s;
  logic             res_last_s;

  // Next position in the pass schedule; cycle counter wraps at P-1
  always_comb begin
    cyc_nx_s  = cyc_q;
    pass_nx_s = pass_q;
    if (cyc_q == CW'(P - 1)) begin
      cyc_nx_s  = '0;
      pass_nx_s = pass_q + PW'(32'd1);
    end else begin
      cyc_nx_s  = cyc_q + CW'(32'd1);
    end
  end

  // Decode which PE (if any) starts at the next position; iterations >= S are skipped
  always_comb begin
    issue_s      = '0;
    issue_it_s   = 0;
    for (int k = 0; k < PE_NB; k++) begin
      if ((int'(pass_nx_s) * PE_NB + k < S) && (cyc_nx_s == CW'(k * PE_DELAY))) begin
        issue_s[k] = 1'b1;
        issue_it_s = int'(pass_nx_s) * PE_NB + k;
      end else begin
        issue_s[k] = 1'b0;
      end
    end
    issue_last_s = (|issue_s) && (issue_it_s == S - 1);
    ashift_nx_s  = (cyc_nx_s == CW'(ASH)) && (pass_nx_s != PW'(NP - 1));
  end

`ifdef FIOS_SEQ_SCHED_QUEUE_EN
  logic pend_q;
  logic pend_d;

  // Start acceptance with a one-entry pending slot; the done cycle counts as busy
  always_comb begin
    busy_s     = (state_q != ST_IDLE);
    done_cyc_s = (state_q == ST_DRAIN) && done_q;
    launch_s   = ((state_q == ST_IDLE) && bus.start_i) ||
                 (done_cyc_s && (pend_q || bus.start_i));
    drop_s     = bus.start_i && busy_s && pend_q;
    if (done_cyc_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q || (bus.start_i && busy_s);
    end
  end

  // Pending start flag
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  // Start acceptance: any start while busy (including the done cycle) is dropped
  always_comb begin
    busy_s     = (state_q != ST_IDLE);
    done_cyc_s = (state_q == ST_DRAIN) && done_q;
    launch_s   = (state_q == ST_IDLE) && bus.start_i;
    drop_s     = bus.start_i && busy_s;
  end
`endif

  // Window loads: fetch at every pass start, result push RES_LAT cycles after the last start
  always_comb begin
    fetch_load_s = launch_s || ((state_q == ST_RUN) && (cyc_nx_s == '0));
    res_load_s   = (state_q == ST_DRAIN) && (lat_q == LW'(32'd1));
  end

  fios_seq_window #(.LEN(S), .CW(RW)) u_fetch_win (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load_i  (fetch_load_s),
    .level_o (fetch_lvl_s),
    .last_o  (fetch_last_unused_s)
  );

  fios_seq_window #(.LEN(S), .CW(RW)) u_res_win (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load_i  (res_load_s),
    .level_o (res_lvl_s),
    .last_o  (res_last_s)
  );

  // Scheduler FSM with all schedule outputs registered
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      pass_q     <= '0;
      lat_q      <= '0;
      busy_q     <= 1'b0;
      pe_start_q <= '0;
      a_shift_q  <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      iter_q     <= '0;
    end else begin
      pe_start_q <= '0;
      a_shift_q  <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= drop_s;
      case (state_q)
        ST_IDLE: begin
          if (launch_s) begin
            state_q    <= ST_RUN;
            cyc_q      <= '0;
            pass_q     <= '0;
            pe_start_q <= PE_NB'(1'b1);
            iter_q     <= '0;
            busy_q     <= 1'b1;
          end else begin
            busy_q     <= 1'b0;
          end
        end
        ST_RUN: begin
          cyc_q      <= cyc_nx_s;
          pass_q     <= pass_nx_s;
          pe_start_q <= issue_s;
          a_shift_q  <= ashift_nx_s;
          busy_q     <= 1'b1;
          if (|issue_s) begin
            iter_q <= IW'(issue_it_s);
          end else begin
            iter_q <= iter_q;
          end
          // Leave RUN on the edge that issues the final iteration
          if (issue_last_s) begin
            state_q <= ST_DRAIN;
            lat_q   <= LW'(RES_LAT);
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - LW'(32'd1);
          end else begin
            lat_q <= lat_q;
          end
          if (done_q) begin
            // Done cycle: either chain straight into a queued operation or go idle
            if (launch_s) begin
              state_q    <= ST_RUN;
              cyc_q      <= '0;
              pass_q     <= '0;
              pe_start_q <= PE_NB'(1'b1);
              iter_q     <= '0;
              busy_q     <= 1'b1;
            end else begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
            end
          end else begin
            done_q <= res_last_s;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.pe_start_o   = pe_start_q;
  assign bus.a_shift_o    = a_shift_q;
  assign bus.b_fetch_o    = fetch_lvl_s;
  assign bus.p_fetch_o    = fetch_lvl_s;
  assign bus.RES_push_o   = res_lvl_s;
  assign bus.done_o       = done_q;
  assign bus.start_drop_o = drop_q;
  assign bus.iter_o       = iter_q;

endmodule

// File: tb/tb_fios_seq_sched.sv
// ---------------------------------------------------------------------------
// tb_fios_seq_sched
// Drives four scheduler instances (reference, partial last pass, single PE,
// default parameters) with the same start/reset stimulus. Each cycle a
// schedule model predicts every output for the next cycle and queues it;
// after the clock edge the prediction is popped and compared.
// ---------------------------------------------------------------------------
module tb_fios_seq_sched;

  localparam int ND   = 4;
  localparam int NONE = -100000;
  localparam int CS   [ND] = '{4, 3, 2, 8};
  localparam int CNB  [ND] = '{2, 2, 1, 3};
  localparam int CPED [ND] = '{3, 3, 1, 7};
  localparam int CLD  [ND] = '{1, 1, 0, 0};
  localparam int CRL  [ND] = '{5, 5, 1, 9};

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fios_seq_sched_if #(.PE_NB(2), .IW(2)) bus0 ();
  fios_seq_sched_if #(.PE_NB(2), .IW(2)) bus1 ();
  fios_seq_sched_if #(.PE_NB(1), .IW(1)) bus2 ();
  fios_seq_sched_if #(.PE_NB(3), .IW(3)) bus3 ();

  fios_seq_sched #(.S(4), .PE_NB(2), .PE_DELAY(3), .LOOP_DELAY(1), .RES_LAT(5))
    dut0 (.clock_i(clk), .reset_i(rst), .bus(bus0));
  fios_seq_sched #(.S(3), .PE_NB(2), .PE_DELAY(3), .LOOP_DELAY(1), .RES_LAT(5))
    dut1 (.clock_i(clk), .reset_i(rst), .bus(bus1));
  fios_seq_sched #(.S(2), .PE_NB(1), .PE_DELAY(1), .LOOP_DELAY(0), .RES_LAT(1))
    dut2 (.clock_i(clk), .reset_i(rst), .bus(bus2));
  fios_seq_sched dut3 (.clock_i(clk), .reset_i(rst), .bus(bus3));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0_m   [ND];
  bit pend_m [ND];
  int iter_m [ND];
  logic [17:0] sbq [$];

  function automatic int m_p(int d);
    int ring;
    ring = CNB[d] * CPED[d] + CLD[d];
    return (ring > CS[d] + 2) ? ring : CS[d] + 2;
  endfunction

  function automatic int m_np(int d);
    return (CS[d] + CNB[d] - 1) / CNB[d];
  endfunction

  function automatic int m_dur(int d);
    int ls;
    ls = (m_np(d) - 1) * m_p(d) + ((CS[d] - 1) % CNB[d]) * CPED[d];
    return ls + CRL[d] + CS[d];
  endfunction

  // Bit layout: busy a b p res done drop 0 pe[3:0] iter[3:0]
  function automatic logic [15:0] pk(input logic b, input logic a, input logic f,
                                     input logic p, input logic rp, input logic dn,
                                     input logic dr, input logic [3:0] pe,
                                     input logic [3:0] it);
    return {b, a, f, p, rp, dn, dr, 1'b0, pe, it};
  endfunction

  // Expected outputs r cycles after t0 of the running operation
  task automatic model_out(input int d, input int r, input logic drop, output logic [15:0] v);
    int dur, pp, np, rs0;
    logic [3:0] pe;
    logic b, a, f, rp, dn;
    dur = m_dur(d); pp = m_p(d); np = m_np(d);
    rs0 = dur - CS[d];
    pe = 4'd0; b = 1'b0; a = 1'b0; f = 1'b0; rp = 1'b0; dn = 1'b0;
    if (r >= 0 && r <= dur) begin
      b = 1'b1;
      for (int n = 0; n < np; n++) begin
        for (int k = 0; k < CNB[d]; k++) begin
          if (n * CNB[d] + k < CS[d] && r == n * pp + k * CPED[d]) begin
            pe[k] = 1'b1;
            iter_m[d] = n * CNB[d] + k;
          end
        end
        if (r >= n * pp && r < n * pp + CS[d]) f = 1'b1;
        if (n < np - 1 && r == n * pp + (CNB[d] - 1) * CPED[d] + 1) a = 1'b1;
      end
      rp = (r >= rs0 && r < dur);
      dn = (r == dur);
    end
    v = pk(b, a, f, f, rp, dn, drop, pe, 4'(iter_m[d]));
  endtask

  // Advance the model by one cycle of inputs and predict the next cycle
  task automatic model_step(input int d, input logic st, input logic rs, output logic [15:0] v);
    int dur, rel;
    logic drop;
    bit busy_c, done_c;
    drop = 1'b0;
    if (rs) begin
      t0_m[d] = NONE; pend_m[d] = 1'b0; iter_m[d] = 0;
      v = 16'h0000;
    end else begin
      dur = m_dur(d);
      rel = cyc - t0_m[d];
      busy_c = (rel >= 0) && (rel <= dur);
      done_c = busy_c && (rel == dur);
`ifdef FIOS_SEQ_SCHED_QUEUE_EN
      if (done_c) begin
        if (pend_m[d]) begin
          t0_m[d] = cyc + 1; pend_m[d] = 1'b0; drop = st;
        end else if (st) begin
          t0_m[d] = cyc + 1;
        end
      end else if (st) begin
        if (!busy_c) t0_m[d] = cyc + 1;
        else if (pend_m[d]) drop = 1'b1;
        else pend_m[d] = 1'b1;
      end
`else
      if (st) begin
        if (busy_c) drop = 1'b1;
        else t0_m[d] = cyc + 1;
      end
`endif
      model_out(d, cyc + 1 - t0_m[d], drop, v);
    end
  endtask

  task automatic tick(input logic st, input logic rs);
    logic [15:0] ev;
    logic [15:0] obs [ND];
    logic [17:0] ent;
    for (int d = 0; d < ND; d++) begin
      model_step(d, st, rs, ev);
      sbq.push_back({d[1:0], ev});
    end
    bus0.start_i = st; bus1.start_i = st; bus2.start_i = st; bus3.start_i = st;
    rst = rs;
    @(posedge clk);
    #1;
    obs[0] = pk(bus0.busy_o, bus0.a_shift_o, bus0.b_fetch_o, bus0.p_fetch_o, bus0.RES_push_o,
                bus0.done_o, bus0.start_drop_o, 4'(bus0.pe_start_o), 4'(bus0.iter_o));
    obs[1] = pk(bus1.busy_o, bus1.a_shift_o, bus1.b_fetch_o, bus1.p_fetch_o, bus1.RES_push_o,
                bus1.done_o, bus1.start_drop_o, 4'(bus1.pe_start_o), 4'(bus1.iter_o));
    obs[2] = pk(bus2.busy_o, bus2.a_shift_o, bus2.b_fetch_o, bus2.p_fetch_o, bus2.RES_push_o,
                bus2.done_o, bus2.start_drop_o, 4'(bus2.pe_start_o), 4'(bus2.iter_o));
    obs[3] = pk(bus3.busy_o, bus3.a_shift_o, bus3.b_fetch_o, bus3.p_fetch_o, bus3.RES_push_o,
                bus3.done_o, bus3.start_drop_o, 4'(bus3.pe_start_o), 4'(bus3.iter_o));
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $error("FAIL sbq_empty dut%0d cycle %0d got %h expected entry", d, cyc + 1, obs[d]);
      end else begin
        ent = sbq.pop_front();
        assert (ent === {d[1:0], obs[d]}) else begin
          errors++;
          $error("FAIL sched dut%0d cycle %0d got %h expected %h", d, cyc + 1, obs[d], ent[15:0]);
        end
      end
    end
    cyc++;
  endtask

  function automatic bit all_idle();
    for (int d = 0; d < ND; d++) begin
      if ((cyc - t0_m[d]) <= m_dur(d) || pend_m[d]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic settle();
    int n;
    n = 0;
    while (!all_idle() && n < 400) begin
      tick(1'b0, 1'b0);
      n++;
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      t0_m[d] = NONE; pend_m[d] = 1'b0; iter_m[d] = 0;
    end
    bus0.start_i = 1'b0; bus1.start_i = 1'b0; bus2.start_i = 1'b0; bus3.start_i = 1'b0;

    // Reset state
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);

    // Reference schedule with a second start at relative cycle 6
    tick(1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    settle();

    // Start on the reference done cycle (relative 20)
    tick(1'b1, 1'b0);
    repeat (19) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    settle();

    // Starts at 0, 8, 16: hits the single-PE and partial-pass done cycles,
    // and a start while a request is already pending on the longer ones
    tick(1'b1, 1'b0);
    repeat (7) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (7) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    settle();

    // Reset mid-operation at 9, fresh start at 12
    tick(1'b1, 1'b0);
    repeat (8) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
